// File: rtl/data_packer.sv
// Byte-stream re-framer: cuts the input into packets of a configurable length and marks tlast.
// Define DATA_PACKER_HDR_EN to prepend a one-beat tag header to every packet.
module data_packer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           confi,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

`ifdef DATA_PACKER_HDR_EN
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
  logic [7:0] tag;
`else
  typedef enum logic [0:0] {IDLE, PAYLOAD} state_t;
  logic unused_tag;
  assign unused_tag = ^confi[15:8];
`endif

  state_t state, state_nx;
  logic [8:0] len, cnt, cnt_inc, len_cfg;
  logic                  skid_v, skid_last, skid_v_nx;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  push, push_last, out_free;
  logic [DATA_WIDTH-1:0] push_data;

  assign len_cfg  = (confi[7:0] == 8'd0) ? 9'd256 : {1'b0, confi[7:0]};
  assign cnt_inc  = cnt + 9'd1;
  assign out_free = !m_axis_tvalid || m_axis_tready;

  // push: one beat (header or payload) enters the output register / skid pair this cycle
  always_comb begin
    push      = 1'b0;
    push_data = s_axis_tdata;
    push_last = 1'b0;
    state_nx  = state;
    case (state)
      IDLE: begin
`ifdef DATA_PACKER_HDR_EN
        // header goes out in the same cycle the config is latched
        push      = 1'b1;
        push_data = DATA_WIDTH'(confi[15:8]);
`endif
        state_nx  = PAYLOAD;
      end
`ifdef DATA_PACKER_HDR_EN
      HDR: begin
        if (!skid_v) begin
          push      = 1'b1;
          push_data = DATA_WIDTH'(tag);
          state_nx  = PAYLOAD;
        end
      end
`endif
      PAYLOAD: begin
        push      = s_axis_tvalid && s_axis_tready;
        push_last = (cnt_inc == len) || s_axis_tlast;
        if (push && push_last) begin
`ifdef DATA_PACKER_HDR_EN
          state_nx = HDR;
`else
          state_nx = PAYLOAD;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
    skid_v_nx = !out_free && (skid_v || push);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      len           <= '0;
      cnt           <= '0;
`ifdef DATA_PACKER_HDR_EN
      tag           <= '0;
`endif
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      skid_v        <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
    end else begin
      state         <= state_nx;
      // ready only reflects registered state: free skid slot and a payload phase ahead
      s_axis_tready <= (state_nx == PAYLOAD) && !skid_v_nx;

      if (state == IDLE || (push && push_last)) begin
        len <= len_cfg;
        cnt <= '0;
`ifdef DATA_PACKER_HDR_EN
        tag <= confi[15:8];
`endif
      end else if (push && state == PAYLOAD) begin
        cnt <= cnt_inc;
      end

      if (out_free) begin
        if (skid_v) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= skid_data;
          m_axis_tlast  <= skid_last;
          skid_v        <= 1'b0;
        end else begin
          m_axis_tvalid <= push;
          if (push) begin
            m_axis_tdata <= push_data;
            m_axis_tlast <= push_last;
          end
        end
      end else if (push) begin
        skid_v    <= 1'b1;
        skid_data <= push_data;
        skid_last <= push_last;
      end
    end
  end

endmodule

// File: tb/tb_data_packer.sv
// Scoreboard bench for data_packer: a reference model pushes expected beats as input is accepted.
module tb_data_packer;
  localparam int DW = 8;
`ifdef DATA_PACKER_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   confi = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;

  data_packer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .confi(confi),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] sb[$];
  bit drv_done;
  int mcnt, mlen;

  function automatic int cfg_len();
    return (confi[7:0] == 8'd0) ? 256 : int'(confi[7:0]);
  endfunction

  // packet model restarts on every reset
  task automatic do_reset();
    reset = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    sb.delete();
    mcnt = 0;
    mlen = cfg_len();
    if (HDR) sb.push_back({1'b0, confi[15:8]});
    reset = 1'b1;
  endtask

  task automatic drive_frame(input int n, input bit last_at_end, input bit rnd);
    int i = 0;
    int guard = 0;
    logic lst;
    while (i < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata  = DW'(i);
      s_axis_tlast  = last_at_end && (i == n - 1);
      if (s_axis_tvalid && s_axis_tready) begin
        mcnt++;
        lst = (mcnt == mlen) || s_axis_tlast;
        sb.push_back({lst, s_axis_tdata});
        if (lst) begin
          mcnt = 0;
          mlen = cfg_len();
          if (HDR) sb.push_back({1'b0, confi[15:8]});
        end
        i++;
      end
    end
    if (i < n) begin
      n_chk++; n_fail++;
      $display("FAIL drive_timeout: sent %0d beats, required %0d", i, n);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    drv_done = 1'b1;
  endtask

  task automatic consume(input string name, input bit rnd);
    int guard = 0;
    bit stalled = 1'b0;
    logic [9:0] prev = '0;
    logic [8:0] exp;
    while ((!drv_done || sb.size() > 0) && guard < 20000) begin
      @(negedge clk);
      guard++;
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        n_chk++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== prev) begin
          n_fail++;
          $display("FAIL %s_stall_hold: got %h, required %h", name,
                   {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, prev);
        end
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      prev = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra_beat: got last=%b data=%h, required no beat", name,
                   m_axis_tlast, m_axis_tdata);
        end else begin
          exp = sb.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== exp) begin
            n_fail++;
            $display("FAIL %s_beat: got last=%b data=%h, required last=%b data=%h", name,
                     m_axis_tlast, m_axis_tdata, exp[8], exp[7:0]);
          end
        end
      end
    end
    if (guard >= 20000) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: %0d beats outstanding, required 0", name, sb.size());
    end
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_after: got tvalid=%b, required 0", name, m_axis_tvalid);
    end
  endtask

  task automatic test_reset();
    confi = 16'h0410;
    reset = 1'b0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b rdy=%b, required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready);
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: got %b, required 1", s_axis_tready);
    end
`ifdef DATA_PACKER_HDR_EN
    n_chk++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b10, 8'h04}) begin
      n_fail++;
      $display("FAIL reset_first_header: got v=%b l=%b d=%h, required v=1 l=0 d=04",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
`endif
  endtask

  task automatic test_basic();
    confi = 16'h0410;
    do_reset();
    drv_done = 1'b0;
    fork
      drive_frame(16, 1'b1, 1'b0);
      consume("basic", 1'b0);
    join
  endtask

  task automatic test_split();
    confi = 16'h0A04;
    do_reset();
    drv_done = 1'b0;
    fork
      drive_frame(10, 1'b1, 1'b0);
      consume("split", 1'b0);
    join
  endtask

  task automatic test_backpressure();
    confi = 16'h0410;
    do_reset();
    drv_done = 1'b0;
    fork
      drive_frame(16, 1'b1, 1'b1);
      consume("bp", 1'b1);
    join
    confi = 16'h0A04;
    do_reset();
    drv_done = 1'b0;
    fork
      drive_frame(23, 1'b1, 1'b1);
      consume("bp_split", 1'b1);
    join
  endtask

  task automatic test_len256();
    confi = 16'h0700;
    do_reset();
    drv_done = 1'b0;
    fork
      drive_frame(300, 1'b1, 1'b0);
      consume("len256", 1'b0);
    join
  endtask

  task automatic test_reset_abort();
    confi = 16'h0308;
    do_reset();
    drv_done = 1'b0;
    fork
      drive_frame(5, 1'b0, 1'b0);
      consume("abort_pre", 1'b0);
    join
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset_outputs: got v=%b d=%h l=%b rdy=%b, required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready);
    end
    do_reset();
    drv_done = 1'b0;
    fork
      drive_frame(8, 1'b1, 1'b0);
      consume("abort_post", 1'b0);
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_backpressure();
    test_len256();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_packer.md
# data_packer

Stream re-framer that sits between a byte-stream source and a downstream AXI-Stream consumer. It cuts the incoming stream into packets of a runtime-configurable payload length and marks the last byte of each packet with `m_axis_tlast`. When the header feature is compiled in, it also prepends a one-beat tag header to every packet. It has full AXI-Stream valid/ready handshaking on both sides, with a registered output stage.

## Interface
- `DATA_WIDTH`, default 8: width of `s_axis_tdata` and `m_axis_tdata`.
- `clk`: input, 1 bit. Single clock; everything is rising-edge.
- `reset`: input, 1 bit. Asynchronous, active-low reset.
- `confi`: input, 16 bits.
  - `[7:0]` = payload length L; 0 means 256.
  - `[15:8]` = header tag.
- `s_axis_tdata`: input, DATA_WIDTH. Input byte.
- `s_axis_tvalid`: input, 1 bit. Input beat valid.
- `s_axis_tready`: output, 1 bit. Packer accepts the input beat.
- `s_axis_tlast`: input, 1 bit. Input end of frame.
- `m_axis_tdata`: output, DATA_WIDTH. Output beat.
- `m_axis_tvalid`: output, 1 bit. Output beat valid.
- `m_axis_tready`: input, 1 bit. Consumer accepts the output beat.
- `m_axis_tlast`: output, 1 bit. Last beat of the output packet.

## Operation
- States: IDLE, HDR, PAYLOAD.
- IDLE
  - Latch L and the tag from `confi`.
  - Clear the payload counter.
  - Go to HDR, or to PAYLOAD when the header feature is absent.
  - `confi` is sampled only here. Changes mid-packet take effect at the next packet.
- HDR
  - Emit one beat: data = `confi[15:8]` zero-extended, or truncated, to DATA_WIDTH; `m_axis_tlast`=0.
  - No input is consumed; `s_axis_tready`=0.
  - Go to PAYLOAD when the beat is loaded into the output register.
- PAYLOAD
  - Each accepted input beat is forwarded unchanged and the counter increments.
  - `m_axis_tlast`=1 when the counter reaches L or when `s_axis_tlast`=1, whichever comes first.
  - Then return to IDLE.
  - Simultaneous count==L and `s_axis_tlast` ends a single packet; no empty packet follows.
  - An input frame longer than L is split into consecutive packets, each with its own header.
  - An input frame shorter than L produces a short packet that ends on the input tlast.
- Counter is 9 bits, so L=256 is representable; there is no wrap within a packet.
- No bytes are dropped, duplicated or reordered under any backpressure pattern.

## Timing
- Reset (`reset`=0):
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `s_axis_tready`=0.
  - State=IDLE, counter=0.
- `s_axis_tready` rises the first cycle after reset is released.
- Reset asserted mid-packet aborts the packet immediately. The next packet starts fresh, with its header.
- Latency: an input beat accepted at edge n appears on `m_axis_*` after edge n; one cycle.
- Output register plus one-entry skid buffer. With `m_axis_tready`=1 steady, throughput is 1 beat per cycle.
- Each header costs one input stall cycle.
- `s_axis_tready` is driven from registers only, with no combinational path from `m_axis_tready`.
- AXI-Stream rules:
  - Once `m_axis_tvalid`=1, data, last and valid hold until `m_axis_tready`=1.
  - A transfer occurs on a rising edge with valid & ready both high.
- IDLE to HDR costs no extra cycle. The header beat can follow the previous tlast beat back-to-back.

## Configuration
- Macro: `DATA_PACKER_HDR_EN`.
- Defined:
  - HDR state present.
  - Each packet is L+1 beats for full packets: tag, then payload.
- Undefined:
  - HDR state removed; `confi[15:8]` ignored.
  - Packets contain payload only.
  - No input stall cycles.

## Test plan
- Reset: hold `reset`=0 with `s_axis_tvalid`=1 → all outputs 0 and no transfers. Release → `s_axis_tready`=1 one cycle later.
- `confi`=16'h0410, input bytes 0x00..0x0F with tlast on 0x0F, `m_axis_tready`=1 → 17 output beats: 0x04, 0x00..0x0F, with `m_axis_tlast` only on 0x0F. Macro undefined → 16 beats, tlast on 0x0F.
- `confi`=16'h0A04, input 0x00..0x09 with tlast on 0x09 → three packets:
  - 0x0A,0x00..0x03 (last on 0x03)
  - 0x0A,0x04..0x07 (last on 0x07)
  - 0x0A,0x08,0x09 (last on 0x09)
- Random `m_axis_tready` (~50%) and random `s_axis_tvalid` with `confi`=16'h0410 → scoreboard matches the second scenario. Output stays stable while stalled.
- `confi[7:0]`=0, 300-byte frame → first packet carries 256 payload bytes with last on byte 255. Second packet carries 44 bytes with last on byte 299.
- Assert `reset` after 5 payload beats of a packet, then release and resend → the aborted packet is not completed. The new packet starts with the header beat and has the full length.
